mem_access_unit: RTL

// Multicycle memory interface that sits directly downstream of the main control FSM.
// It turns the FSM's per-state memory controls (address source, instruction-write,

---
 rtl/mem_bus_if.sv | 24 ++
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_if.sv
// Single-outstanding valid/ready memory bus between the access unit and the memory.
// The master issues one request at a time; read data returns later on rvalid/rdata.
interface mem_bus_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [3:0]            wstrb;
  logic [31:0]           wdata;
  logic                  rvalid;
  logic [31:0]           rdata;

  modport master (
    output valid, addr, we, wstrb, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, we, wstrb, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multicycle memory access unit: turns the control FSM's per-state memory controls into one
// bus transaction at a time, holds the instruction register and returns extended load data.
module mem_access_unit #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          TIMEOUT    = 64,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_addr_src,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic [ADDR_WIDTH-1:0] i_result,
  input  logic                  i_instr_write_en,
  input  logic                  i_load_req,
  input  logic                  i_mem_write_en,
  input  logic [2:0]            i_func_3,
  input  logic [31:0]           i_write_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fault,
  output logic [31:0]           o_instr,
  output logic [31:0]           o_read_data,
  mem_bus_if.master             bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

  state_t           state;
  kind_t            kind;
  logic [2:0]       func_3;
  logic [1:0]       lane;
  logic [CNT_W-1:0] tmo_cnt;

  logic                  start;
  kind_t                 start_kind;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic                  start_ok;
  logic                  tmo_hit;

  function automatic logic access_ok(input kind_t k, input logic [2:0] f3, input logic [1:0] ln);
    logic ok;
    ok = 1'b0;
    case (k)
      K_FETCH: ok = (ln == 2'b00);
      K_STORE: begin
        case (f3)
          3'b000:  ok = 1'b1;
          3'b001:  ok = !ln[0];
          3'b010:  ok = (ln == 2'b00);
          default: ok = 1'b0;
        endcase
      end
      default: begin
        case (f3)
          3'b000, 3'b100: ok = 1'b1;
          3'b001, 3'b101: ok = !ln[0];
          3'b010:         ok = (ln == 2'b00);
          default:        ok = 1'b0;
        endcase
      end
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] ln,
                                              input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[{ln, 3'b000} +: 8];
    h = word[{ln[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = 32'(b);
      3'b001:  r = 32'(h);
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] ln);
    case (f3)
      3'b000:  return 4'b0001 << ln;
      3'b001:  return 4'b0011 << ln;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000:  return {4{wd[7:0]}};
      3'b001:  return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  always_comb begin
    start      = i_mem_write_en | i_instr_write_en | i_load_req;
    start_kind = i_mem_write_en ? K_STORE : (i_instr_write_en ? K_FETCH : K_LOAD);
    start_addr = i_mem_addr_src ? i_result : i_pc;
    start_ok   = access_ok(start_kind, i_func_3, start_addr[1:0]);
    tmo_hit    = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      kind        <= K_FETCH;
      func_3      <= 3'b000;
      lane        <= 2'b00;
      tmo_cnt     <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_fault     <= 1'b0;
      o_instr     <= NOP_INSTR;
      o_read_data <= 32'd0;
      bus.valid   <= 1'b0;
      bus.addr    <= '0;
      bus.we      <= 1'b0;
      bus.wstrb   <= 4'b0000;
      bus.wdata   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          o_done  <= 1'b0;
          o_fault <= 1'b0;
          if (start) begin
            kind   <= start_kind;
            func_3 <= i_func_3;
            lane   <= start_addr[1:0];
            o_busy <= 1'b1;
            if (!start_ok) begin
              // Rejected before touching the bus: report straight away.
              state   <= S_DONE;
              o_done  <= 1'b1;
              o_fault <= 1'b1;
            end else begin
              state     <= S_REQ;
              tmo_cnt   <= '0;
              bus.valid <= 1'b1;
              bus.addr  <= {start_addr[ADDR_WIDTH-1:2], 2'b00};
              bus.we    <= (start_kind == K_STORE);
              bus.wstrb <= (start_kind == K_STORE) ? store_strobe(i_func_3, start_addr[1:0])
                                                   : 4'b0000;
              if (start_kind == K_STORE)
                bus.wdata <= store_data(i_func_3, i_write_data);
            end
          end
        end
        S_REQ: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (bus.ready) begin
            bus.valid <= 1'b0;
            if (kind == K_STORE) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end else if (tmo_hit) begin
            bus.valid <= 1'b0;
            state     <= S_DONE;
            o_done    <= 1'b1;
            o_fault   <= 1'b1;
          end
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (bus.rvalid) begin
            if (kind == K_FETCH) o_instr <= bus.rdata;
            else                 o_read_data <= load_extend(bus.rdata, lane, func_3);
            state  <= S_DONE;
            o_done <= 1'b1;
          end else if (tmo_hit) begin
            state   <= S_DONE;
            o_done  <= 1'b1;
            o_fault <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          o_done  <= 1'b0;
          o_fault <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
